// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the single-port memory arbiter.
// Port indices identify which requester owns an outstanding read response:
//   PORT_IF - instruction-fetch requester (P0)
//   PORT_LS - load/store requester (P1)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_IF = 1'b0;
    localparam port_idx_t PORT_LS = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_cnt
// Saturating wait counter for one low-priority requester. Counts consecutive
// cycles in which the requester asked but was not granted and raises force_o
// once the count reaches LIMIT. LIMIT = 0 disables the mechanism entirely.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   inc_i    - requester denied this cycle: count up (saturating), else clear
//   force_o  - count has reached LIMIT; the arbiter must grant this requester
// -----------------------------------------------------------------------------
module mem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    output logic force_o
);

    // $clog2(1) is 0, so a disabled counter still keeps one bit.
    localparam int               CNT_W   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (LIMIT != 0) && (cnt_q == CNT_MAX);

endmodule : mem_arb_starve_cnt

// File: rtl/mem_sp_arbiter.sv
// -----------------------------------------------------------------------------
// mem_sp_arbiter
// Shares one synchronous single-port memory (1-cycle registered read, byte
// write enables) between an instruction-fetch port (P0) and a load/store port
// (P1). P1 has fixed priority; a starvation counter forces a P0 grant after
// STARVE_LIMIT consecutive denied cycles. Read data returns to the owning
// port one cycle after its grant; the pipeline overlaps with no bubble.
//
// Ports:
//   clk, rst_n                 - clock / asynchronous active-low reset
//   i_pN_req/addr/wdata/wen    - requester N command; wen == 0 means read
//   o_pN_gnt                   - command of port N accepted at the next edge
//   o_pN_rvalid / o_pN_rdata   - read data for port N (rdata qualified by rvalid)
//   o_mem_addr/wdata/wen       - memory command (all zero when idle)
//   i_mem_rdata                - registered memory read data
// -----------------------------------------------------------------------------
module mem_sp_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = DATA_WIDTH,
    parameter int DATA_BYTES   = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_p0_req,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    input  logic [DATA_BYTES-1:0] i_p0_wen,
    output logic                  o_p0_gnt,
    output logic                  o_p0_rvalid,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,

    input  logic                  i_p1_req,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    input  logic [DATA_BYTES-1:0] i_p1_wen,
    output logic                  o_p1_gnt,
    output logic                  o_p1_rvalid,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,

    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    logic      force0;
    logic      gnt0;
    logic      gnt1;

    logic      resp_valid_q;
    logic      resp_valid_d;
    port_idx_t resp_owner_q;
    port_idx_t resp_owner_d;

    // ------------------------------------------------------------------
    // Grant: P1 wins unless P0 has waited long enough and is still asking.
    // Grants are qualified by rst_n so the memory sees a quiet bus (and no
    // write) for as long as reset is held, even if requesters keep asking.
    // ------------------------------------------------------------------
    always_comb begin
        gnt1 = rst_n && i_p1_req && !(force0 && i_p0_req);
        gnt0 = rst_n && i_p0_req && !gnt1;
    end

    assign o_p0_gnt = gnt0;
    assign o_p1_gnt = gnt1;

    mem_arb_starve_cnt #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (i_p0_req && !gnt0),
        .force_o (force0)
    );

    // ------------------------------------------------------------------
    // Memory command mux. Idle cycles issue a harmless read of address 0.
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wen   = '0;
        if (gnt0) begin
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
            o_mem_wen   = i_p0_wen;
        end else if (gnt1) begin
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
            o_mem_wen   = i_p1_wen;
        end
    end

    // ------------------------------------------------------------------
    // Response tracker: remembers who issued the read accepted at this edge.
    // The owner only changes on a read grant; valid alone gates the return.
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid_d = 1'b0;
        resp_owner_d = resp_owner_q;
        if (gnt0 && (i_p0_wen == '0)) begin
            resp_valid_d = 1'b1;
            resp_owner_d = PORT_IF;
        end else if (gnt1 && (i_p1_wen == '0)) begin
            resp_valid_d = 1'b1;
            resp_owner_d = PORT_LS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= PORT_IF;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign o_p0_rvalid = resp_valid_q && (resp_owner_q == PORT_IF);
    assign o_p1_rvalid = resp_valid_q && (resp_owner_q == PORT_LS);
    assign o_p0_rdata  = i_mem_rdata;
    assign o_p1_rdata  = i_mem_rdata;

endmodule : mem_sp_arbiter

// File: tb/tb_mem_sp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_sp_arbiter
// Drives mem_sp_arbiter (STARVE_LIMIT = 4) attached to a behavioural
// single-port memory, plus a second instance with STARVE_LIMIT = 0 sharing the
// same request inputs. Read responses are predicted from a reference memory
// image into a scoreboard queue and compared when rvalid appears.
// -----------------------------------------------------------------------------
module tb_mem_sp_arbiter;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          p0_req = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [BW-1:0] p0_wen = '0;
    logic          p1_req = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic [BW-1:0] p1_wen = '0;

    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_wen;
    logic [DW-1:0] mem_rdata = '0;

    logic          z_p0_gnt, z_p0_rvalid, z_p1_gnt, z_p1_rvalid;
    logic [DW-1:0] z_p0_rdata, z_p1_rdata, z_mem_wdata;
    logic [AW-1:0] z_mem_addr;
    logic [BW-1:0] z_mem_wen;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    logic sim_stop   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTES(BW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_wen(p0_wen),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_wen(p1_wen),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
        .i_mem_rdata(mem_rdata)
    );

    mem_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTES(BW), .STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_wen(p0_wen),
        .o_p0_gnt(z_p0_gnt), .o_p0_rvalid(z_p0_rvalid), .o_p0_rdata(z_p0_rdata),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_wen(p1_wen),
        .o_p1_gnt(z_p1_gnt), .o_p1_rvalid(z_p1_rvalid), .o_p1_rdata(z_p1_rdata),
        .o_mem_addr(z_mem_addr), .o_mem_wdata(z_mem_wdata), .o_mem_wen(z_mem_wen),
        .i_mem_rdata(64'd0)
    );

    // Memory behind the arbiter (word index = byte address [10:3]) and the
    // bench's own image of what it should contain, fed from the stimulus side.
    logic [DW-1:0] mem_model [256] = '{32: 64'h0000_0000_DEAD_BEEF, 33: 64'hA5A5_0000_1111_2222,
                                       34: 64'h0BAD_F00D_3333_4444, default: 64'd0};
    logic [DW-1:0] ref_mem   [256] = '{32: 64'h0000_0000_DEAD_BEEF, 33: 64'hA5A5_0000_1111_2222,
                                       34: 64'h0BAD_F00D_3333_4444, default: 64'd0};

    always @(posedge clk) begin
        for (int b = 0; b < BW; b++)
            if (mem_wen[b]) mem_model[mem_addr[10:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem_model[mem_addr[10:3]];
        if (mem_wen != '0 && mem_addr == 64'h50) sim_stop <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expected read returns are queued at the grant and popped
    // when due one cycle later.
    // ------------------------------------------------------------------
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    resp_t sb[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
            check("rst_gnt", {p0_gnt, p1_gnt}, 0);
            check("rst_mem_wen", mem_wen, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                resp_t e;
                e = sb.pop_front();
                check("rvalid_p0", p0_rvalid, (e.port == 1'b0));
                check("rvalid_p1", p1_rvalid, (e.port == 1'b1));
                check(e.port ? "rdata_p1" : "rdata_p0", e.port ? p1_rdata : p0_rdata, e.data);
            end else begin
                check("no_rvalid", {p0_rvalid, p1_rvalid}, 0);
            end
            check("gnt_onehot", p0_gnt & p1_gnt, 0);
            if (p0_gnt || p1_gnt) begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic [BW-1:0] w;
                a = p0_gnt ? p0_addr : p1_addr;
                d = p0_gnt ? p0_wdata : p1_wdata;
                w = p0_gnt ? p0_wen : p1_wen;
                if (w == '0) sb.push_back('{port: p1_gnt, data: ref_mem[a[10:3]], due: cyc + 1});
                for (int b = 0; b < BW; b++)
                    if (w[b]) ref_mem[a[10:3]][8*b +: 8] <= d[8*b +: 8];
            end else begin
                check("idle_mem_cmd", {mem_addr, mem_wdata, 8'(mem_wen)} == '0, 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        string         name;
        logic          r0;
        logic [AW-1:0] a0;
        logic [BW-1:0] w0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [AW-1:0] a1;
        logic [BW-1:0] w1;
        logic [DW-1:0] d1;
        logic          g0;
        logic          g1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r0, logic [AW-1:0] a0, logic [BW-1:0] w0,
                                logic [DW-1:0] d0, logic r1, logic [AW-1:0] a1,
                                logic [BW-1:0] w1, logic [DW-1:0] d1, logic g0, logic g1);
        vec_t v;
        v.name = n; v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        p0_req = v.r0; p0_addr = v.a0; p0_wen = v.w0; p0_wdata = v.d0;
        p1_req = v.r1; p1_addr = v.a1; p1_wen = v.w1; p1_wdata = v.d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t idle;

    initial begin
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back(mk("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("p0_read_100", 1, 64'h100, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("idle_rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk($sformatf("contend%0d", k), 1, 64'h108, 0, 0, 1, 64'h110, 0, 0,
                              (k % 5) == 4, (k % 5) != 4));
        vecs.push_back(mk("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pipe_p1_wr", 0, 0, 0, 0, 1, 64'h208, 8'hFF, 64'hCAFE_0123_4567_89AB, 0, 1));
        vecs.push_back(mk("pipe_p0_rd", 1, 64'h100, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("pipe_p1_rd", 0, 0, 0, 0, 1, 64'h208, 0, 0, 0, 1));
        vecs.push_back(mk("pipe_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("p0_read_60", 1, 64'h60, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset held for a few cycles, released away from a clock edge.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check({vecs[i].name, ".gnt0"}, p0_gnt, vecs[i].g0);
            check({vecs[i].name, ".gnt1"}, p1_gnt, vecs[i].g1);
            check({vecs[i].name, ".mem_addr"}, mem_addr,
                  vecs[i].g1 ? vecs[i].a1 : (vecs[i].g0 ? vecs[i].a0 : 64'd0));
            check({vecs[i].name, ".mem_wen"}, mem_wen,
                  vecs[i].g1 ? vecs[i].w1 : (vecs[i].g0 ? vecs[i].w0 : 8'd0));
            check({vecs[i].name, ".mem_wdata"}, mem_wdata,
                  vecs[i].g1 ? vecs[i].d1 : (vecs[i].g0 ? vecs[i].d0 : 64'd0));
            next_cycle();
        end

        // Partial byte write followed by a read of the same word.
        drive(mk("bw_wr", 0, 0, 0, 0, 1, 64'h200, 8'h0F, 64'h1122_3344_5566_7788, 0, 1));
        @(negedge clk);
        check("bw_wr.gnt1", p1_gnt, 1);
        next_cycle();
        drive(mk("bw_rd", 0, 0, 0, 0, 1, 64'h200, 0, 0, 0, 1));
        @(negedge clk);
        check("bw_wr.no_rvalid", p1_rvalid, 0);
        next_cycle();
        drive(idle);
        @(negedge clk);
        check("bw_rd.rvalid", p1_rvalid, 1);
        check("bw_rd.rdata", p1_rdata, 64'h0000_0000_5566_7788);
        next_cycle();

        // Pure fixed priority instance: P0 must never win.
        drive(mk("nostarve", 1, 64'h108, 0, 0, 1, 64'h110, 0, 0, 0, 1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("limit0.gnt0", z_p0_gnt, 0);
            check("limit0.gnt1", z_p1_gnt, 1);
            check("limit0.starve_cnt", 64'(dut0.u_starve.cnt_q), 0);
            next_cycle();
        end
        drive(idle);
        next_cycle();

        // Reset in the middle of a read: the pending response is dropped and
        // the bus stays quiet even with a write request pending.
        drive(mk("rst_rd", 1, 64'h100, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        check("rst_rd.gnt0", p0_gnt, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(mk("rst_wr", 0, 0, 0, 0, 1, 64'h300, 8'hFF, 64'h5555_AAAA_5555_AAAA, 0, 0));
        @(negedge clk);
        check("rst_mid.p0_rvalid", p0_rvalid, 0);
        check("rst_mid.mem_wen", mem_wen, 0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        drive(mk("post_rst", 1, 64'h108, 0, 0, 1, 64'h300, 8'hFF, 64'h5555_AAAA_5555_AAAA, 0, 1));
        @(negedge clk);
        check("post_rst.gnt1", p1_gnt, 1);
        check("post_rst.gnt0", p0_gnt, 0);
        next_cycle();
        drive(idle);
        next_cycle();

        // Simulation-control writes pass through untouched.
        drive(mk("ctl40", 1, 64'h40, 8'hFF, 64'h1, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        check("ctl40.mem_addr", mem_addr, 64'h40);
        next_cycle();
        drive(mk("ctl50", 0, 0, 0, 0, 1, 64'h50, 8'hFF, 64'h1, 0, 1));
        @(negedge clk);
        check("ctl50.mem_addr", mem_addr, 64'h50);
        next_cycle();
        drive(idle);
        for (int k = 0; k < 5 && !sim_stop; k++) next_cycle();
        check("ctl50.sim_stop", sim_stop, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_mem_sp_arbiter
